brightness_enhancer: RTL and testbench
======================================

// Module: brightness_enhancer
// PURPOSE
// - Adaptive brightness stage in the 8-bit grayscale pixel stream.
// - Each pixel leaves as pixel_in + offset, saturated to 0..255.
// - The offset is derived from the mean of the previous complete frame, which pulls the frame mean toward TARGET_MEAN.
// - Sits between the video source and downstream filters. There is no back-pressure.
// PARAMETERS
// - TARGET_MEAN  128  desired frame mean (0..255)
// - MAX_OFFSET   64   offset magnitude limit, used only with BE_OFFSET_LIMIT_EN (0..128)
// PORTS
// - clk           in   1   rising-edge clock, single clock domain
// - reset         in   1   asynchronous, active-high reset
// - pixel_in      in   8   input pixel, unsigned
// - valid         in   1   pixel_in is valid this cycle
// - total_pixels  in   32  pixels per frame; sampled on the first valid pixel of each frame
// - pixel_out     out  8   enhanced pixel
// - valid_out     out  1   pixel_out is valid
// BEHAVIOUR
// - Reset (asynchronous): pixel_out=0, valid_out=0, offset=0, pixel count=0, sum=0, divider idle.
//   Reset mid-frame discards the partial frame.
// - Datapath, 1-cycle latency. On each valid cycle, at the next edge:
//   - pixel_out <= sat8(pixel_in + offset)
//   - valid_out <= valid
//   - When valid=0: valid_out<=0 and pixel_out holds its value.
// - Arithmetic: offset is signed 9-bit. The sum is computed in 10-bit signed, then clamped: <0 gives 0, >255 gives 255.
// - Frame accounting:
//   - 40-bit sum accumulates pixel_in; 32-bit count increments on each valid.
//   - When the count reaches the sampled total_pixels:
//     - sum and count are latched to the divider;
//     - the accumulators clear in the same cycle;
//     - the next valid pixel starts a new frame.
//   - Gaps (valid=0) are allowed anywhere and do not advance the count.
// - total_pixels=0: no frame boundary is ever reached. Sum saturates at all-ones and offset is never updated.
// - Divider: restoring serial divider, mean = floor(sum/count), 40 iterations (1 bit/cycle).
//   - States: IDLE -> DIV (40 cycles) -> UPD (1 cycle) -> IDLE.
//   - In UPD: offset <= TARGET_MEAN - mean (clamped to 8-bit mean first).
//   - The new offset applies to the first pixel accepted after UPD.
//   - Pixels arriving during DIV use the old offset.
// - A frame end that arrives while the divider is not IDLE drops that frame's statistics. The divider is not restarted. Accumulation of the next frame still restarts normally.
// - Frame end and valid in the same cycle: that pixel is the last pixel of the frame and is included in the sum.
// CONFIGURATION
// - BE_OFFSET_LIMIT_EN defined: offset is clamped to [-MAX_OFFSET, +MAX_OFFSET] in UPD.
// - BE_OFFSET_LIMIT_EN undefined: offset = TARGET_MEAN - mean, unclamped (range -127..+128).
// TESTING
// Defaults: TARGET_MEAN=128, MAX_OFFSET=64, limit macro undefined unless stated.
// - Reset, total=16, 16 pixels of 64, then idle 45 cycles, then pixels of 64:
//   - frame 1 outputs 64 (offset 0);
//   - frame 2 outputs 128;
//   - valid_out trails valid by exactly 1 cycle.
// - 16 pixels of 32, then pixel 200 -> offset +96, output 255 (saturation).
//   - Same test with BE_OFFSET_LIMIT_EN: offset +64, outputs 96 for pixel 32 and 255 for 200.
// - 16 pixels of 250, then pixels 100 and 250:
//   - offset -122, outputs 0 (floor clamp) and 128.
// - Frame of 16 with valid toggling every other cycle:
//   - sum/count include only valid cycles;
//   - mean is correct;
//   - valid_out mirrors the valid pattern delayed by 1 cycle.
// - Reset asserted after 8 pixels:
//   - outputs go to 0 immediately;
//   - after release, a full 16-pixel frame of 64 yields offset +64;
//   - the partial frame has no effect.
// - total=4 with back-to-back frames (shorter than divider time):
//   - the second frame end is ignored while busy;
//   - offset reflects frame 1;
//   - a later frame updates the offset after the divider returns to IDLE.

Source files
------------

// File: rtl/brightness_enhancer.sv
// Adaptive brightness stage for an 8-bit grayscale pixel stream: pixel_out = sat8(pixel_in + offset).
// Latency: 1 cycle from valid/pixel_in to valid_out/pixel_out; the offset tracks the previous frame's mean.
// Backpressure: none. One pixel is accepted on every cycle where valid is high.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   pixel_in      input pixel (unsigned 8-bit), qualified by valid
//   valid         pixel_in is valid this cycle
//   total_pixels  pixels per frame, sampled on the first valid pixel of each frame (0 = no frame boundary)
//   pixel_out     enhanced pixel; holds its value on cycles without valid
//   valid_out     pixel_out is valid (valid delayed by one cycle)
//
// Optional build macro: BE_OFFSET_LIMIT_EN clamps the offset to [-MAX_OFFSET, +MAX_OFFSET].
// When it is undefined, the offset is TARGET_MEAN - mean without a limit.

module brightness_enhancer #(
    parameter int TARGET_MEAN = 128,
    parameter int MAX_OFFSET  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pixel_in,
    input  logic        valid,
    input  logic [31:0] total_pixels,
    output logic [7:0]  pixel_out,
    output logic        valid_out
);

    localparam logic signed [9:0] LP_TARGET  = 10'(TARGET_MEAN);
    localparam logic signed [9:0] LP_MAX_OFF = 10'(MAX_OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_UPD  = 2'd2
    } div_state_t;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic signed [8:0] r_offset;
    logic [39:0]       r_sum;
    logic [31:0]       r_count;
    logic [31:0]       r_total;

    div_state_t        r_state;
    logic [39:0]       r_quo;      // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [31:0]       r_rem;
    logic [31:0]       r_div;
    logic [5:0]        r_iter;

    // ---------------------------------------------------------------
    // Pixel datapath
    // ---------------------------------------------------------------
    logic signed [9:0] w_sum_px;
    logic [7:0]        w_pix_sat;

    assign w_sum_px  = $signed({2'b00, pixel_in}) + $signed({r_offset[8], r_offset});
    assign w_pix_sat = w_sum_px[9] ? 8'd0 :
                       w_sum_px[8] ? 8'd255 : w_sum_px[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_out <= 8'd0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid;
            if (valid) begin
                pixel_out <= w_pix_sat;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame accounting
    // ---------------------------------------------------------------
    logic [31:0] w_frame_total;
    logic [31:0] w_count_nxt;
    logic [40:0] w_sum_ext;
    logic [39:0] w_sum_nxt;
    logic        w_frame_end;

    // The frame length is taken from the port on the first pixel of a frame,
    // so the pixel that opens the frame already sees the fresh value.
    assign w_frame_total = (r_count == 32'd0) ? total_pixels : r_total;
    assign w_count_nxt   = r_count + 32'd1;
    assign w_sum_ext     = {1'b0, r_sum} + {33'd0, pixel_in};
    // The sum only saturates when frames never end (total_pixels = 0).
    assign w_sum_nxt     = w_sum_ext[40] ? {40{1'b1}} : w_sum_ext[39:0];
    assign w_frame_end   = valid && (w_frame_total != 32'd0) && (w_count_nxt == w_frame_total);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum   <= 40'd0;
            r_count <= 32'd0;
            r_total <= 32'd0;
        end else if (valid) begin
            if (r_count == 32'd0) begin
                r_total <= total_pixels;
            end
            if (w_frame_end) begin
                r_sum   <= 40'd0;
                r_count <= 32'd0;
            end else begin
                r_sum   <= w_sum_nxt;
                r_count <= w_count_nxt;
            end
        end
    end

    // ---------------------------------------------------------------
    // Restoring serial divider and offset update
    // ---------------------------------------------------------------
    logic [32:0]       w_rem_sh;
    logic              w_div_ge;
    logic [31:0]       w_rem_sub;
    logic [7:0]        w_mean8;
    logic signed [9:0] w_off_raw;
    logic signed [9:0] w_off_new;

    assign w_rem_sh  = {r_rem, r_quo[39]};
    assign w_div_ge  = (w_rem_sh >= {1'b0, r_div});
    // When the subtraction is taken the result is below the divisor, so the
    // low 32 bits of the difference are the full remainder.
    assign w_rem_sub = w_rem_sh[31:0] - r_div;

    assign w_mean8   = (|r_quo[39:8]) ? 8'd255 : r_quo[7:0];
    assign w_off_raw = LP_TARGET - $signed({2'b00, w_mean8});

`ifdef BE_OFFSET_LIMIT_EN
    assign w_off_new = (w_off_raw > LP_MAX_OFF)  ? LP_MAX_OFF :
                       (w_off_raw < -LP_MAX_OFF) ? -LP_MAX_OFF : w_off_raw;
`else
    assign w_off_new = w_off_raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_quo    <= 40'd0;
            r_rem    <= 32'd0;
            r_div    <= 32'd0;
            r_iter   <= 6'd0;
            r_offset <= 9'sd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A frame end seen while the divider is busy is simply not captured here.
                    if (w_frame_end) begin
                        r_quo   <= w_sum_nxt;
                        r_div   <= w_count_nxt;
                        r_rem   <= 32'd0;
                        r_iter  <= 6'd0;
                        r_state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    r_rem  <= w_div_ge ? w_rem_sub : w_rem_sh[31:0];
                    r_quo  <= {r_quo[38:0], w_div_ge};
                    r_iter <= r_iter + 6'd1;
                    if (r_iter == 6'd39) begin
                        r_state <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    r_offset <= w_off_new[8:0];
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brightness_enhancer.sv
// Self-checking bench for brightness_enhancer: random and directed pixel streams scored against a frame-level model.
// Latency: expected outputs are queued per stimulus cycle and compared one cycle later on the falling edge.
// Backpressure: none; the monitor pops one expected entry per cycle whenever the queue holds one.

module tb_brightness_enhancer;

    localparam int TARGET = 128;
    localparam int MAXO   = 64;
    localparam longint SUM_MAX = 64'h0000_00FF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pixel_in = 8'd0;
    logic        valid = 1'b0;
    logic [31:0] total_pixels = 32'd0;
    logic [7:0]  pixel_out;
    logic        valid_out;

    always #5 clk = ~clk;

    brightness_enhancer #(
        .TARGET_MEAN (TARGET),
        .MAX_OFFSET  (MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pixel_in),
        .valid        (valid),
        .total_pixels (total_pixels),
        .pixel_out    (pixel_out),
        .valid_out    (valid_out)
    );

    typedef struct {
        bit v;
        int p;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_n = 0;

    // Frame-level reference: offset, accumulation of the current frame and
    // the pending offset that becomes visible once the divider finishes.
    int     m_off;
    int     m_last;
    int     m_cnt;
    int     m_tot;
    longint m_sum;
    bit     m_pend;
    int     pend_off;
    int     upd_edge;

    task automatic model_reset();
        m_off    = 0;
        m_last   = 0;
        m_cnt    = 0;
        m_tot    = 0;
        m_sum    = 0;
        m_pend   = 1'b0;
        pend_off = 0;
        upd_edge = -1;
        q.delete();
    endtask

    function automatic int offset_for(input longint sum, input int cnt);
        int mean;
        int off;
        mean = int'(sum / longint'(cnt));
        if (mean > 255) mean = 255;
        off = TARGET - mean;
`ifdef BE_OFFSET_LIMIT_EN
        if (off > MAXO) off = MAXO;
        if (off < -MAXO) off = -MAXO;
`endif
        return off;
    endfunction

    // Drives one cycle of input; the model is evaluated at the sampling edge.
    // A frame completed at edge c occupies the divider through edge c+41, and
    // the new offset applies to pixels sampled from edge c+42 on.
    task automatic step(input bit v, input int p, input int tot);
        exp_t e;
        int   s;
        valid        = v;
        pixel_in     = p[7:0];
        total_pixels = 32'(tot);
        @(posedge clk);
        edge_n++;
        if (m_pend && edge_n > upd_edge) begin
            m_off  = pend_off;
            m_pend = 1'b0;
        end
        if (v) begin
            s = p + m_off;
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            m_last = s;
        end
        e.v = v;
        e.p = m_last;
        q.push_back(e);
        if (v) begin
            if (m_cnt == 0) m_tot = tot;
            m_sum = m_sum + longint'(p);
            if (m_sum > SUM_MAX) m_sum = SUM_MAX;
            m_cnt++;
            if (m_tot != 0 && m_cnt == m_tot) begin
                if (edge_n > upd_edge) begin
                    pend_off = offset_for(m_sum, m_cnt);
                    m_pend   = 1'b1;
                    upd_edge = edge_n + 41;
                end
                m_sum = 0;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input int tot);
        for (int i = 0; i < n; i++) step(1'b0, 0, tot);
    endtask

    task automatic burst(input int n, input int p, input int tot);
        for (int i = 0; i < n; i++) step(1'b1, p, tot);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        total++;
        if (pixel_out !== 8'd0 || valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got px=%0d v=%0d, want px=0 v=0", pixel_out, valid_out);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (valid_out !== e.v || int'(pixel_out) != e.p) begin
                bad++;
                $display("FAIL out@edge%0d: got v=%0d px=%0d, want v=%0d px=%0d",
                         edge_n, valid_out, pixel_out, e.v, e.p);
            end
        end
    end

    initial begin
        model_reset();
        #2;
        do_reset();

        // Two frames of 64: first passes unchanged, second is lifted to 128.
        burst(16, 64, 16);
        idle(45, 16);
        burst(16, 64, 16);
        idle(45, 16);
        burst(4, 64, 16);

        // Dark frame, then upper saturation.
        do_reset();
        burst(16, 32, 16);
        idle(45, 16);
        step(1'b1, 32, 16);
        step(1'b1, 200, 16);
        step(1'b1, 32, 16);

        // Bright frame, then lower clamp.
        do_reset();
        burst(16, 250, 16);
        idle(45, 16);
        step(1'b1, 100, 16);
        step(1'b1, 250, 16);

        // Frame with valid toggling every other cycle.
        do_reset();
        for (int i = 0; i < 32; i++) step((i % 2) == 0, 90 + i, 16);
        idle(45, 16);
        step(1'b1, 100, 16);
        step(1'b0, 7, 16);
        step(1'b1, 20, 16);

        // Reset in the middle of a frame discards it.
        do_reset();
        burst(8, 200, 16);
        do_reset();
        burst(16, 64, 16);
        idle(45, 16);
        step(1'b1, 64, 16);
        step(1'b1, 10, 16);

        // Short frames arrive faster than the divider completes.
        do_reset();
        burst(4, 64, 4);
        burst(4, 200, 4);
        burst(4, 30, 4);
        idle(45, 4);
        step(1'b1, 64, 4);
        burst(3, 10, 4);
        idle(45, 4);
        step(1'b1, 100, 4);
        step(1'b1, 0, 4);

        // Random traffic with a varying frame length offered on every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                idle(int'($urandom_range(30, 60)), int'($urandom_range(3, 12)));
            end else begin
                step($urandom_range(0, 99) < 70, int'($urandom_range(0, 255)),
                     int'($urandom_range(3, 12)));
            end
        end
        valid = 1'b0;

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
